mips_mc_ctrl: RTL and testbench

Multicycle control FSM that sequences the shared 32-bit ALU, register file, unified memory port and PC for a MIPS subset. It decodes opcode/funct from the instruction register and drives the ALU operation code and datapath mux selects state by state. It stalls on a memory ready handshake and reports retirement and illegal instructions.

---
 rtl/mips_mc_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_ctrl.sv
// Multicycle control FSM for a MIPS subset (addu/subu/and/or, lw/sw, ori/lui,
// beq, j). Sequences a shared ALU, register file, unified memory port and PC.
// Memory accesses stall on mem_ready.
//
// Ports:
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   opcode, funct      IR[31:26] and IR[5:0]
//   zero               ALU zero flag, used for beq
//   mem_ready          memory access completes this cycle
//   ALUctr             ALU operation code
//   ALUSrcA/ALUSrcB    ALU operand selects
//   ExtOp              1 = sign-extend immediate, 0 = zero-extend
//   IorD               memory address select (0 = PC, 1 = ALUOut)
//   MemRead/MemWrite   memory requests
//   IRWrite, PCWrite   IR load, PC load
//   PCSource           PC source select
//   RegWrite/RegDst/MemtoReg  register-file write controls
//   instr_done         one-cycle pulse on retirement
//   illegal            one-cycle pulse on an undecodable instruction
//   state              current state, for debug
module mips_mc_ctrl #(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [3:0] ALUctr,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ExtOp,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic [1:0] PCSource,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC_R = 4'd7,
    S_RWB    = 4'd8,
    S_EXEC_I = 4'd9,
    S_IWB    = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12,
    S_HALT   = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;

  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_LUI  = 4'b1010;

  state_t state_q;
  state_t dispatch;
  logic   dec_ok;

  // DECODE dispatch; undecodable instructions fall back to refetch or halt.
  always_comb begin
    dec_ok   = 1'b1;
    dispatch = S_FETCH;
    case (opcode)
      OP_RTYPE: begin
        if (funct inside {FN_ADDU, FN_SUBU, FN_AND, FN_OR}) dispatch = S_EXEC_R;
        else dec_ok = 1'b0;
      end
      OP_LW, OP_SW:   dispatch = S_MEMADR;
      OP_ORI, OP_LUI: dispatch = S_EXEC_I;
      OP_BEQ:         dispatch = S_BRANCH;
      OP_J:           dispatch = S_JUMP;
      default:        dec_ok = 1'b0;
    endcase
    if (!dec_ok) dispatch = ILLEGAL_TRAP ? S_HALT : S_FETCH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   state_q <= S_FETCH;
        S_FETCH:  if (mem_ready) state_q <= S_DECODE;
        S_DECODE: state_q <= dispatch;
        S_MEMADR: state_q <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (mem_ready) state_q <= S_MEMWB;
        S_MEMWB:  state_q <= S_FETCH;
        S_MEMWR:  if (mem_ready) state_q <= S_FETCH;
        S_EXEC_R: state_q <= S_RWB;
        S_RWB:    state_q <= S_FETCH;
        S_EXEC_I: state_q <= S_IWB;
        S_IWB:    state_q <= S_FETCH;
        S_BRANCH: state_q <= S_FETCH;
        S_JUMP:   state_q <= S_FETCH;
        S_HALT:   state_q <= S_HALT;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  // Output decode. The handshake-qualified strobes (IRWrite/PCWrite in FETCH,
  // PCWrite in BRANCH, instr_done in MEMWR, illegal in DECODE) depend on
  // same-cycle inputs, so outputs are decoded from the state register rather
  // than registered.
  always_comb begin
    ALUctr     = '0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = '0;
    ExtOp      = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    PCSource   = '0;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'd1;
        ALUctr  = ALU_ADD;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB = 2'd3;
        ExtOp   = 1'b1;
        ALUctr  = ALU_ADD;
        illegal = !dec_ok;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
        ExtOp   = 1'b1;
        ALUctr  = ALU_ADD;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        case (funct)
          FN_SUBU: ALUctr = ALU_SUB;
          FN_AND:  ALUctr = ALU_AND;
          FN_OR:   ALUctr = ALU_OR;
          default: ALUctr = ALU_ADD;
        endcase
      end
      S_RWB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
        ALUctr  = (opcode == OP_LUI) ? ALU_LUI : ALU_OR;
      end
      S_IWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUctr     = ALU_SUB;
        PCSource   = 2'd1;
        PCWrite    = zero;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        PCSource   = 2'd2;
        PCWrite    = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Testbench for mips_mc_ctrl: a table of per-cycle {inputs, expected state,
// expected outputs} records applied in sequence, plus hand-written sequences
// for asynchronous reset mid-access and the illegal-instruction trap.
module tb_mips_mc_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;

  // Instance with ILLEGAL_TRAP=0
  logic [3:0] n_aluctr, n_state;
  logic       n_srca, n_extop, n_iord, n_memread, n_memwrite, n_irwrite, n_pcwrite;
  logic [1:0] n_srcb, n_pcsource;
  logic       n_regwrite, n_regdst, n_memtoreg, n_done, n_illegal;
  // Instance with ILLEGAL_TRAP=1
  logic [3:0] t_aluctr, t_state;
  logic       t_srca, t_extop, t_iord, t_memread, t_memwrite, t_irwrite, t_pcwrite;
  logic [1:0] t_srcb, t_pcsource;
  logic       t_regwrite, t_regdst, t_memtoreg, t_done, t_illegal;

  mips_mc_ctrl #(.ILLEGAL_TRAP(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .ALUctr(n_aluctr), .ALUSrcA(n_srca), .ALUSrcB(n_srcb),
    .ExtOp(n_extop), .IorD(n_iord), .MemRead(n_memread), .MemWrite(n_memwrite),
    .IRWrite(n_irwrite), .PCWrite(n_pcwrite), .PCSource(n_pcsource),
    .RegWrite(n_regwrite), .RegDst(n_regdst), .MemtoReg(n_memtoreg),
    .instr_done(n_done), .illegal(n_illegal), .state(n_state)
  );

  mips_mc_ctrl #(.ILLEGAL_TRAP(1'b1)) dut_t (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .ALUctr(t_aluctr), .ALUSrcA(t_srca), .ALUSrcB(t_srcb),
    .ExtOp(t_extop), .IorD(t_iord), .MemRead(t_memread), .MemWrite(t_memwrite),
    .IRWrite(t_irwrite), .PCWrite(t_pcwrite), .PCSource(t_pcsource),
    .RegWrite(t_regwrite), .RegDst(t_regdst), .MemtoReg(t_memtoreg),
    .instr_done(t_done), .illegal(t_illegal), .state(t_state)
  );

  // Output bundle order:
  // ALUctr[4] SrcA SrcB[2] ExtOp IorD MemRead MemWrite IRWrite PCWrite
  // PCSource[2] RegWrite RegDst MemtoReg instr_done illegal
  logic [19:0] out_n, out_t;
  assign out_n = {n_aluctr, n_srca, n_srcb, n_extop, n_iord, n_memread, n_memwrite,
                  n_irwrite, n_pcwrite, n_pcsource, n_regwrite, n_regdst,
                  n_memtoreg, n_done, n_illegal};
  assign out_t = {t_aluctr, t_srca, t_srcb, t_extop, t_iord, t_memread, t_memwrite,
                  t_irwrite, t_pcwrite, t_pcsource, t_regwrite, t_regdst,
                  t_memtoreg, t_done, t_illegal};

  localparam logic [19:0] O_ZERO    = '0;
  localparam logic [19:0] O_FETCH_W = {4'b0010, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [19:0] O_FETCH   = {4'b0010, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [19:0] O_DEC     = {4'b0010, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [19:0] O_DEC_ILL = {4'b0010, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam logic [19:0] O_EXR_ADD = {4'b0010, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [19:0] O_EXR_SUB = {4'b0110, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [19:0] O_EXR_AND = {4'b0111, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [19:0] O_EXR_OR  = {4'b0001, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [19:0] O_RWB     = {4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam logic [19:0] O_EXI_ORI = {4'b0001, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [19:0] O_EXI_LUI = {4'b1010, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [19:0] O_IWB     = {4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [19:0] O_MEMADR  = {4'b0010, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [19:0] O_MEMRD   = {4'b0000, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [19:0] O_MEMWB   = {4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam logic [19:0] O_MEMWR_W = {4'b0000, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [19:0] O_MEMWR_D = {4'b0000, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [19:0] O_BR_T    = {4'b0110, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [19:0] O_BR_N    = {4'b0110, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [19:0] O_JMP     = {4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b111111;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_ADD  = 6'b100000;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        mr;
    logic [3:0]  st;
    logic [19:0] out;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input logic mr, input logic [3:0] st, input logic [19:0] o);
    vec_t v;
    v.op = op; v.fn = fn; v.z = z; v.mr = mr; v.st = st; v.out = o;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [19:0] act,
                     input logic [19:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Apply inputs just after the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input logic mr);
    @(negedge clk);
    opcode = op; funct = fn; zero = z; mem_ready = mr;
    #1;
  endtask

  task automatic apply_reset(input int tag);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_state_n", tag, {16'h0, n_state}, 20'd0);
    chk("rst_outs_n",  tag, out_n, O_ZERO);
    chk("rst_state_t", tag, {16'h0, t_state}, 20'd0);
    chk("rst_outs_t",  tag, out_t, O_ZERO);
    rst_n = 1'b1;
    #1;
    chk("idle_after_release", tag, {16'h0, n_state}, 20'd0);
  endtask

  task automatic add_r(input logic [5:0] fn, input logic [19:0] exo);
    add(OP_R, fn, 1'b0, 1'b1, 4'd1, O_FETCH);
    add(OP_R, fn, 1'b0, 1'b1, 4'd2, O_DEC);
    add(OP_R, fn, 1'b0, 1'b1, 4'd7, exo);
    add(OP_R, fn, 1'b0, 1'b1, 4'd8, O_RWB);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;

    add_r(F_ADDU, O_EXR_ADD);
    add_r(F_SUBU, O_EXR_SUB);
    add_r(F_AND,  O_EXR_AND);
    add_r(F_OR,   O_EXR_OR);
    // lw with three stall cycles in MEMRD: 8 cycles total
    add(OP_LW, 6'd0, 1'b0, 1'b1, 4'd1, O_FETCH);
    add(OP_LW, 6'd0, 1'b0, 1'b1, 4'd2, O_DEC);
    add(OP_LW, 6'd0, 1'b0, 1'b1, 4'd3, O_MEMADR);
    add(OP_LW, 6'd0, 1'b0, 1'b0, 4'd4, O_MEMRD);
    add(OP_LW, 6'd0, 1'b0, 1'b0, 4'd4, O_MEMRD);
    add(OP_LW, 6'd0, 1'b0, 1'b0, 4'd4, O_MEMRD);
    add(OP_LW, 6'd0, 1'b0, 1'b1, 4'd4, O_MEMRD);
    add(OP_LW, 6'd0, 1'b0, 1'b1, 4'd5, O_MEMWB);
    // sw with a fetch stall and two write stalls
    add(OP_SW, 6'd0, 1'b0, 1'b0, 4'd1, O_FETCH_W);
    add(OP_SW, 6'd0, 1'b0, 1'b1, 4'd1, O_FETCH);
    add(OP_SW, 6'd0, 1'b0, 1'b1, 4'd2, O_DEC);
    add(OP_SW, 6'd0, 1'b0, 1'b1, 4'd3, O_MEMADR);
    add(OP_SW, 6'd0, 1'b0, 1'b0, 4'd6, O_MEMWR_W);
    add(OP_SW, 6'd0, 1'b0, 1'b0, 4'd6, O_MEMWR_W);
    add(OP_SW, 6'd0, 1'b0, 1'b1, 4'd6, O_MEMWR_D);
    // ori / lui
    add(OP_ORI, 6'd0, 1'b0, 1'b1, 4'd1,  O_FETCH);
    add(OP_ORI, 6'd0, 1'b0, 1'b1, 4'd2,  O_DEC);
    add(OP_ORI, 6'd0, 1'b0, 1'b1, 4'd9,  O_EXI_ORI);
    add(OP_ORI, 6'd0, 1'b0, 1'b1, 4'd10, O_IWB);
    add(OP_LUI, 6'd0, 1'b0, 1'b1, 4'd1,  O_FETCH);
    add(OP_LUI, 6'd0, 1'b0, 1'b1, 4'd2,  O_DEC);
    add(OP_LUI, 6'd0, 1'b0, 1'b1, 4'd9,  O_EXI_LUI);
    add(OP_LUI, 6'd0, 1'b0, 1'b1, 4'd10, O_IWB);
    // beq taken / not taken, j
    add(OP_BEQ, 6'd0, 1'b1, 1'b1, 4'd1,  O_FETCH);
    add(OP_BEQ, 6'd0, 1'b1, 1'b1, 4'd2,  O_DEC);
    add(OP_BEQ, 6'd0, 1'b1, 1'b1, 4'd11, O_BR_T);
    add(OP_BEQ, 6'd0, 1'b0, 1'b1, 4'd1,  O_FETCH);
    add(OP_BEQ, 6'd0, 1'b0, 1'b1, 4'd2,  O_DEC);
    add(OP_BEQ, 6'd0, 1'b0, 1'b1, 4'd11, O_BR_N);
    add(OP_J,   6'd0, 1'b0, 1'b1, 4'd1,  O_FETCH);
    add(OP_J,   6'd0, 1'b0, 1'b1, 4'd2,  O_DEC);
    add(OP_J,   6'd0, 1'b0, 1'b1, 4'd12, O_JMP);
    // illegal opcode, then an unsupported R-type funct, then recovery
    add(OP_BAD, 6'd0,  1'b0, 1'b1, 4'd1, O_FETCH);
    add(OP_BAD, 6'd0,  1'b0, 1'b1, 4'd2, O_DEC_ILL);
    add(OP_R,   F_ADD, 1'b0, 1'b1, 4'd1, O_FETCH);
    add(OP_R,   F_ADD, 1'b0, 1'b1, 4'd2, O_DEC_ILL);
    add_r(F_ADDU, O_EXR_ADD);

    apply_reset(0);
    foreach (tbl[i]) begin
      drive(tbl[i].op, tbl[i].fn, tbl[i].z, tbl[i].mr);
      chk("state", i, {16'h0, n_state}, {16'h0, tbl[i].st});
      chk("outs",  i, out_n, tbl[i].out);
    end

    // Asynchronous reset while stalled in MEMRD
    drive(OP_LW, 6'd0, 1'b0, 1'b1);
    chk("arst_fetch", 0, {16'h0, n_state}, 20'd1);
    drive(OP_LW, 6'd0, 1'b0, 1'b1);
    drive(OP_LW, 6'd0, 1'b0, 1'b1);
    drive(OP_LW, 6'd0, 1'b0, 1'b0);
    chk("arst_memrd_state", 0, {16'h0, n_state}, 20'd4);
    chk("arst_memrd_outs",  0, out_n, O_MEMRD);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_state_now", 0, {16'h0, n_state}, 20'd0);
    chk("arst_outs_now",  0, out_n, O_ZERO);
    apply_reset(1);

    // Illegal trap: ILLEGAL_TRAP=1 halts, ILLEGAL_TRAP=0 refetches
    drive(OP_BAD, 6'd0, 1'b0, 1'b1);
    chk("trap_fetch_state", 0, {16'h0, t_state}, 20'd1);
    chk("trap_fetch_outs",  0, out_t, O_FETCH);
    drive(OP_BAD, 6'd0, 1'b0, 1'b1);
    chk("trap_dec_outs",    0, out_t, O_DEC_ILL);
    chk("notrap_dec_outs",  0, out_n, O_DEC_ILL);
    for (int k = 0; k < 10; k++) begin
      drive(6'($urandom), 6'($urandom), 1'($urandom), 1'($urandom));
      if (k == 0) chk("notrap_refetch", k, {16'h0, n_state}, 20'd1);
      chk("halt_state", k, {16'h0, t_state}, 20'd13);
      chk("halt_outs",  k, out_t, O_ZERO);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
